// File: rtl/key_rewind.sv
// rtl/key_rewind.sv - inverse AES-128 key schedule, round keys 10 down to 0, one per clock
// Optional KEY_REWIND_BANK_EN adds an 11-entry round-key bank readable through rd_idx/rd_key.

package aes_model_pack;
  localparam int ROUND_COUNT = 10;
  typedef logic [127:0] byte_table;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8 * (255 - int'(b)) +: 8];
  endfunction
endpackage

module key_rewind #(
  parameter int ROUNDS = aes_model_pack::ROUND_COUNT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  aes_model_pack::byte_table last_key,
  input  logic                     start,
  output logic                     busy,
  output logic                     key_valid,
  output aes_model_pack::byte_table round_key,
  output logic [3:0]               round_idx,
  output logic                     done,
  input  logic [3:0]               rd_idx,
  output logic [127:0]             rd_key
);

  if (ROUNDS != 10) begin : g_rounds_check
    $error("key_rewind supports only ROUNDS = 10");
  end

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, next_state;
  logic [127:0] key_reg;
  logic [3:0]   idx_reg;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd10:   return 8'h36;
      4'd9:    return 8'h1b;
      4'd8:    return 8'h80;
      4'd7:    return 8'h40;
      4'd6:    return 8'h20;
      4'd5:    return 8'h10;
      4'd4:    return 8'h08;
      4'd3:    return 8'h04;
      4'd2:    return 8'h02;
      4'd1:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // Undo one expansion round: recover w1..w3 by XOR, then w0 from the recovered w3.
  function automatic logic [127:0] rewind_step(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, p3, rot, sub;
    {w0, w1, w2, w3} = k;
    p3  = w3 ^ w2;
    rot = {p3[23:0], p3[31:24]};
    sub = {aes_model_pack::sbox(rot[31:24]), aes_model_pack::sbox(rot[23:16]),
           aes_model_pack::sbox(rot[15:8]),  aes_model_pack::sbox(rot[7:0])};
    return {w0 ^ sub ^ {rcon(r), 24'h0}, w1 ^ w0, w2 ^ w1, p3};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (idx_reg == 4'd0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_reg <= '0;
      idx_reg <= '0;
    end else if (state == IDLE && start) begin
      key_reg <= last_key;
      idx_reg <= LAST_IDX;
    end else if (state == RUN && idx_reg != 4'd0) begin
      key_reg <= rewind_step(key_reg, idx_reg);
      idx_reg <= idx_reg - 4'd1;
    end
  end

  assign key_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == RUN) && (idx_reg == 4'd0);
  assign round_key = key_reg;
  assign round_idx = idx_reg;

`ifdef KEY_REWIND_BANK_EN
  logic [127:0] bank [0:10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 11; i++) bank[i] <= '0;
      rd_key <= '0;
    end else begin
      if (key_valid) bank[idx_reg] <= key_reg;
      rd_key <= (rd_idx <= 4'd10) ? bank[rd_idx] : '0;
    end
  end
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_key        = '0;
`endif

endmodule

// File: tb/tb_key_rewind.sv
// tb/tb_key_rewind.sv - randomized self-checking bench for key_rewind against a forward key-expansion model
// Bank checks follow KEY_REWIND_BANK_EN.

module tb_key_rewind;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] last_key;
  logic         start;
  logic         busy, key_valid, done;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] rk     [0:10];
  logic [127:0] seen   [0:10];

  always #5 clk = ~clk;

  key_rewind dut (
    .clk(clk), .rst(rst), .last_key(last_key), .start(start),
    .busy(busy), .key_valid(key_valid), .round_key(round_key),
    .round_idx(round_idx), .done(done), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = key;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_run(input logic [127:0] orig, input int restart_at, input bit start_at_done,
                        input string tag);
    expand(orig);
    last_key = rk[10];
    start    = 1'b1;
    step();
    start    = 1'b0;
    last_key = rand128();
    for (int i = 0; i <= 10; i++) begin
      check({tag, "_valid"}, key_valid, 1);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_idx"}, round_idx, 128'(10 - i));
      check({tag, "_key"}, round_key, rk[10-i]);
      check({tag, "_done"}, done, 128'(i == 10));
      seen[10-i] = round_key;
      if (10 - i == restart_at) begin
        start    = 1'b1;
        last_key = rand128();
      end
      if (i == 10 && start_at_done) start = 1'b1;
      step();
      start = 1'b0;
    end
    check({tag, "_end_valid"}, key_valid, 0);
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_done"}, done, 0);
    check({tag, "_end_hold"}, round_key, rk[0]);
  endtask

  initial begin
    rst      = 1'b0;
    last_key = '0;
    start    = 1'b0;
    rd_idx   = 4'd0;
    build_sbox();
    step();
    step();
    check("rst_valid", key_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_key", round_key, 0);
    check("rst_idx", round_idx, 0);
    check("rst_rdkey", rd_key, 0);
    rst = 1'b1;
    step();
    check("idle_valid", key_valid, 0);

    do_run(FIPS_KEY, -1, 1'b0, "fips");
    check("fips_idx10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_idx9", seen[9], 128'hac7766f319fadc2128d12941575c006e);
    check("fips_idx1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_idx0", seen[0], FIPS_KEY);

`ifdef KEY_REWIND_BANK_EN
    rd_idx = 4'd9;
    step();
    check("bank_rd9", rd_key, 128'hac7766f319fadc2128d12941575c006e);
    rd_idx = 4'd12;
    step();
    check("bank_rd12", rd_key, 0);
    rd_idx = 4'd0;
    step();
    check("bank_rd0", rd_key, FIPS_KEY);
`else
    rd_idx = 4'd9;
    step();
    check("nobank_rd9", rd_key, 0);
    rd_idx = 4'd12;
    step();
    check("nobank_rd12", rd_key, 0);
`endif

    do_run(FIPS_KEY, 5, 1'b0, "restart");
    check("restart_final", seen[0], FIPS_KEY);

    do_run(rand128(), -1, 1'b1, "done_start");
    do_run(rand128(), -1, 1'b0, "after_done");

    begin
      int guard = 0;
      expand(rand128());
      last_key = rk[10];
      start    = 1'b1;
      step();
      start    = 1'b0;
      while (round_idx != 4'd4 && guard < 20) begin
        step();
        guard++;
      end
      check("abort_reach_idx4", round_idx, 4);
      rst = 1'b0;
      #1;
      check("abort_valid", key_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_key", round_key, 0);
      check("abort_idx", round_idx, 0);
      check("abort_rdkey", rd_key, 0);
      for (int i = 0; i < 3; i++) begin
        step();
        check("abort_no_done", done, 0);
      end
      rst = 1'b1;
      step();
      check("abort_idle", key_valid, 0);
      do_run(rand128(), -1, 1'b0, "post_abort");
    end

    for (int n = 0; n < 100; n++) begin
      do_run(rand128(), int'($urandom_range(0, 14)), 1'($urandom_range(0, 3) == 0), "rand");
      check("rand_roundtrip", seen[0], rk[0]);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
